store_queue_fwd: RTL

//  Parametrised store queue between the AGU and the dcache. Executed stores enter speculatively;
//  the ROB marks them committed in order, and committed entries drain to the dcache one at a time.

---
 rtl/store_queue_fwd_pkg.sv | 38 +++
 rtl/store_queue_fwd_merge.sv | 62 ++++++
 rtl/store_queue_fwd.sv | 171 +++++++++++++++++
 3 files changed

// File: rtl/store_queue_fwd_pkg.sv
// ============================================================================
// Module  : store_queue_fwd_pkg
// Brief   : Shared types for the store queue: entry record, drain states,
//           MMU exception record and the word-address compare helper.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

package store_queue_fwd_pkg;

  localparam int c_rob_max = 8;

  typedef struct packed {
    logic       ex;
    logic [5:0] code;
  } exception_t;

  typedef struct packed {
    logic [31:0]          addr;
    logic [3:0]           wstrb;
    logic [2:0]           size;
    logic [31:0]          data;
    logic [c_rob_max-1:0] rob;
  } sq_entry_t;

  typedef enum logic [1:0] {
    SQ_IDLE = 2'd0,
    SQ_REQ  = 2'd1,
    SQ_WAIT = 2'd2
  } sq_drain_state_t;

  function automatic logic word_match(logic [29:0] a, logic [29:0] b);
    return a == b;
  endfunction

endpackage

`default_nettype wire

// File: rtl/store_queue_fwd_merge.sv
// ============================================================================
// Module  : sq_fwd_merge
// Brief   : Combinational byte-lane merge; the youngest matching valid entry
//           owning a strobe supplies that lane.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

module sq_fwd_merge
  import store_queue_fwd_pkg::*;
#(
  parameter int DEPTH = 8
) (
  input  sq_entry_t                    entries [DEPTH],
  input  logic      [DEPTH-1:0]        valid,
  input  logic      [$clog2(DEPTH)-1:0] oldest,
  input  logic      [29:0]             ld_word,
  output logic      [31:0]             lane_data,
  output logic      [3:0]              lane_strb,
  output logic                         any_match
);

  localparam int c_iw = $clog2(DEPTH);

  logic [DEPTH-1:0] w_match;
  logic [c_iw-1:0]  w_idx;
  logic             w_unused_fields;

  for (genvar gi = 0; gi < DEPTH; gi++) begin : g_match
    assign w_match[gi] = valid[gi] && word_match(entries[gi].addr[31:2], ld_word);
  end

  assign any_match = |w_match;

  // Walk oldest to youngest so later (younger) writers overwrite each lane.
  always_comb begin
    lane_data = '0;
    lane_strb = '0;
    w_idx     = oldest;
    for (int k = 0; k < DEPTH; k++) begin
      w_idx = oldest + c_iw'(k);
      if (w_match[w_idx]) begin
        for (int b = 0; b < 4; b++) begin
          if (entries[w_idx].wstrb[b]) begin
            lane_data[8*b +: 8] = entries[w_idx].data[8*b +: 8];
            lane_strb[b]        = 1'b1;
          end
        end
      end
    end
  end

  always_comb begin
    w_unused_fields = 1'b0;
    for (int k = 0; k < DEPTH; k++) begin
      w_unused_fields = w_unused_fields ^ (^{entries[k].size, entries[k].rob, entries[k].addr[1:0]});
    end
  end

endmodule

`default_nettype wire

// File: rtl/store_queue_fwd.sv
// ============================================================================
// Module  : store_queue_fwd
// Brief   : Speculative store queue with in-order commit, single-outstanding
//           dcache drain and byte-granular load forwarding.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

module store_queue_fwd
  import store_queue_fwd_pkg::*;
#(
  parameter int DEPTH  = 8,
  parameter int ROB_W  = 4,
  parameter int FWD_EN = 1
) (
  input  logic                     clk,
  input  logic                     resetn,
  input  logic                     flush,
  input  logic                     enq_valid,
  output logic                     enq_ready,
  input  logic [31:0]              enq_addr,
  input  logic [3:0]               enq_wstrb,
  input  logic [2:0]               enq_size,
  input  logic [31:0]              enq_data,
  input  logic [ROB_W-1:0]         enq_rob,
  input  logic                     commit_valid,
  output logic                     commit_ready,
  input  logic [31:0]              ld_addr,
  input  logic [3:0]               ld_wstrb,
  output logic                     fwd_hit,
  output logic [31:0]              fwd_data,
  output logic                     ld_wait,
  output logic                     dcache_req,
  output logic                     dcache_wr,
  output logic [31:0]              dcache_addr,
  output logic [3:0]               dcache_wstrb,
  output logic [2:0]               dcache_size,
  output logic [31:0]              dcache_wdata,
  input  logic                     dcache_addr_ok,
  input  logic                     dcache_data_ok,
  input  exception_t               data_tlb_ex,
  output logic                     drain_done,
  output exception_t               drain_ex,
  output logic [$clog2(DEPTH):0]   count
);

  localparam int c_iw = $clog2(DEPTH);
  localparam int c_pw = c_iw + 1;
  localparam logic [c_pw-1:0] c_ptr_one = c_pw'(1);

  logic [c_pw-1:0] r_head, r_cmt, r_tail;
  sq_entry_t       r_entries [DEPTH];
  sq_drain_state_t r_state, w_state_nxt;
  exception_t      r_drain_ex;
  logic            r_drain_done;

  logic            w_full, w_enq, w_commit, w_drain_fire;
  logic [c_pw-1:0] w_cmt_nxt, w_head_inc;
  logic [DEPTH-1:0] w_valid;
  logic [31:0]     w_lane_data;
  logic [3:0]      w_lane_strb, w_cov;
  logic            w_any_match;
  logic            w_unused_ld;
  sq_entry_t       w_head_e;

  assign w_full       = (r_tail[c_iw-1:0] == r_head[c_iw-1:0]) && (r_tail[c_iw] != r_head[c_iw]);
  assign enq_ready    = !w_full;
  assign commit_ready = (r_cmt != r_tail);
  assign count        = r_tail - r_head;
  assign w_enq        = enq_valid && enq_ready && !flush;
  assign w_commit     = commit_valid && commit_ready;
  assign w_cmt_nxt    = w_commit ? (r_cmt + c_ptr_one) : r_cmt;
  assign w_head_inc   = r_head + c_ptr_one;
  assign w_unused_ld  = ^ld_addr[1:0];

  always_ff @(posedge clk) begin
    if (w_enq) begin
      r_entries[r_tail[c_iw-1:0]] <= '{addr: enq_addr, wstrb: enq_wstrb, size: enq_size,
                                       data: enq_data, rob: c_rob_max'(enq_rob)};
    end
  end

  // Flush rolls tail back to the commit point, including a commit in this same cycle.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      r_head       <= '0;
      r_cmt        <= '0;
      r_tail       <= '0;
      r_drain_done <= 1'b0;
      r_drain_ex   <= '0;
    end else begin
      r_cmt        <= w_cmt_nxt;
      r_drain_done <= w_drain_fire;
      if (flush)      r_tail <= w_cmt_nxt;
      else if (w_enq) r_tail <= r_tail + c_ptr_one;
      if (w_drain_fire) begin
        r_head     <= w_head_inc;
        r_drain_ex <= data_tlb_ex;
      end
    end
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) r_state <= SQ_IDLE;
    else         r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt  = r_state;
    w_drain_fire = 1'b0;
    dcache_req   = 1'b0;
    case (r_state)
      SQ_IDLE: if (r_head != r_cmt) w_state_nxt = SQ_REQ;
      SQ_REQ: begin
        dcache_req = 1'b1;
        if (dcache_addr_ok) w_state_nxt = SQ_WAIT;
      end
      SQ_WAIT: if (dcache_data_ok) begin
        w_drain_fire = 1'b1;
        w_state_nxt  = (w_head_inc != r_cmt) ? SQ_REQ : SQ_IDLE;
      end
      default: w_state_nxt = SQ_IDLE;
    endcase
  end

  assign w_head_e     = r_entries[r_head[c_iw-1:0]];
  assign dcache_wr    = dcache_req;
  assign dcache_addr  = dcache_req ? w_head_e.addr  : '0;
  assign dcache_wstrb = dcache_req ? w_head_e.wstrb : '0;
  assign dcache_size  = dcache_req ? w_head_e.size  : '0;
  assign dcache_wdata = dcache_req ? w_head_e.data  : '0;
  assign drain_done   = r_drain_done;
  assign drain_ex     = r_drain_ex;

  for (genvar gi = 0; gi < DEPTH; gi++) begin : g_valid
    logic [c_iw-1:0] w_age;
    assign w_age       = c_iw'(gi) - r_head[c_iw-1:0];
    assign w_valid[gi] = ({1'b0, w_age} < count);
  end

  sq_fwd_merge #(.DEPTH(DEPTH)) u_merge (
    .entries   (r_entries),
    .valid     (w_valid),
    .oldest    (r_head[c_iw-1:0]),
    .ld_word   (ld_addr[31:2]),
    .lane_data (w_lane_data),
    .lane_strb (w_lane_strb),
    .any_match (w_any_match)
  );

  assign w_cov = w_lane_strb & ld_wstrb;

  if (FWD_EN != 0) begin : g_fwd
    logic w_unused_any;
    assign w_unused_any = w_any_match;
    assign fwd_hit  = (ld_wstrb != 4'd0) && (w_cov == ld_wstrb);
    assign ld_wait  = (w_cov != 4'd0) && !fwd_hit;
    assign fwd_data = w_lane_data & {{8{w_cov[3]}}, {8{w_cov[2]}}, {8{w_cov[1]}}, {8{w_cov[0]}}};
  end else begin : g_nofwd
    logic w_unused_fwd;
    assign w_unused_fwd = ^{w_lane_data, w_cov};
    assign fwd_hit  = 1'b0;
    assign ld_wait  = w_any_match;
    assign fwd_data = '0;
  end

  a_commit_legal: assert property (@(posedge clk) disable iff (!resetn) commit_valid |-> commit_ready);

endmodule

`default_nettype wire
